bullet_motion: RTL
==================

# bullet_motion

Per-bullet motion controller for the tank game. Launches a bullet from a tank's position on a fire request, advances it once per video frame, and reflects its velocity using the four wall flags produced by the arena wall-collision stage, which evaluates the bullet's current position each frame. Retires the bullet on lifetime expiry, bounce limit, or a tank hit. Outputs feed the wall-collision stage (position/size) and the sprite renderer.

## Interface
- BULLET_SIZE, 10'd4: half-size in pixels, driven on bulletS.
- LIFETIME, 600: frames a bullet lives, from 1 to 1023.
- MAX_BOUNCE, 5: reflections allowed; the next reflection retires the bullet.

- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-low reset.
- frame_clk  in  1  VGA vsync-rate frame clock, asynchronous to Clk.
- fire  in  1  level fire request, synchronous to Clk.
- tankX, tankY  in  10  launch position, unsigned pixels.
- velX, velY  in  10  launch velocity per frame, two's complement.
- hit  in  1  bullet struck a tank; single-cycle or level.
- isWallBottom, isWallTop, isWallRight, isWallLeft  in  1  flags from the wall-collision stage for the current bulletX/Y; at most one is set.
- bulletX, bulletY  out  10  bullet centre.
- bulletS  out  10  constant BULLET_SIZE.
- active  out  1  bullet in flight.
- bounces  out  3  reflections so far.

## Operation
- Frame tick: two-flop synchroniser on frame_clk, then rising-edge detect. The result is frame_tick, one Clk cycle wide, once per frame.
- Fire edge: fire_d registers fire. fire_rise = fire & ~fire_d. A held button launches at most once.
- States: IDLE, FLY.
- IDLE, on fire_rise:
  - load bulletX/Y = tankX/Y, vx/vy = velX/velY, life = LIFETIME, bounces = 0.
  - go to FLY. active = 1.
- FLY, on frame_tick, evaluated in this order:
  1. hit → IDLE.
  2. Reflect: bottom & vy>0, or top & vy<0 → vy = −vy. right & vx>0, or left & vx<0 → vx = −vx. A flag against an already-receding velocity has no effect.
  3. If a reflection occurred and bounces == MAX_BOUNCE → IDLE, position not updated. Otherwise bounces += 1 on reflection.
  4. bulletX += vx', bulletY += vy', using the post-reflection velocity, modulo 1024.
  5. life −= 1. If life reaches 0 → IDLE, after the move.
- FLY, hit without frame_tick: → IDLE on that edge.
- fire_rise while in FLY is ignored and not queued.
- On entry to IDLE: active = 0. bulletX/Y and bounces hold their last values for debug. The renderer gates on active.
- Corners: the wall-collision stage reports one wall per frame, so a corner reflects over two consecutive frames and counts two bounces.
- Arithmetic:
  - Velocity negation is 10-bit two's complement. −512 is unspecified; the caller must not supply it.
  - Sign is bit 9.

## Timing
- Reset asserted: immediately state = IDLE; bulletX = bulletY = 0; vx = vy = 0; life = 0; bounces = 0; active = 0; fire_d = 0; synchroniser flops = 0. bulletS is always BULLET_SIZE.
- Reset mid-flight aborts the bullet. After release, a new launch needs a fresh fire rising edge as seen by fire_d.
- Launch latency: fire_rise in cycle N → active and loaded position visible in N+1.
- frame_clk rise → frame_tick asserted 2–3 Clk cycles later. Position update is visible the cycle after frame_tick.
- Wall flags are sampled in the frame_tick cycle. They are combinational from the current bulletX/Y, so a flag reflects the pre-move position.
- hit and frame_tick in the same cycle: hit wins. No move, no reflection, no bounce increment.
- fire_rise on the same edge that FLY → IDLE: ignored, because the state is still FLY. A launch needs a later rising edge.
- Single bullet per instance. The tank module instantiates N copies for N bullets.

## Test plan
- Reset: hold Reset low mid-flight, then release → all outputs 0, active = 0, state IDLE; fire held high across release does not launch.
- Launch/straight flight: tank (100,200), vel (+3,−2), fire pulse → next cycle active = 1, position (100,200). After 3 frames → (109,194), bounces = 0.
- Bottom bounce: vy = +4, isWallBottom = 1 on a frame_tick → vy becomes −4, bulletY decreases by 4 that frame, bounces = 1. The flag held on the next frame has no further effect.
- Lifetime: LIFETIME = 5, no walls → moves exactly 5 times; active drops on the 5th frame_tick edge. fire_rise on that same edge is ignored; a later fire_rise relaunches.
- Bounce limit: MAX_BOUNCE = 2, alternate left/right flags against the approaching velocity → bounces 1, 2; the third reflection retires the bullet with the position unchanged.
- Hit priority: hit and frame_tick together with isWallTop set → active = 0, position and bounces unchanged. fire held during flight produces no relaunch until it is released and re-pressed.

Source files
------------

// File: rtl/bullet_motion_if.sv
// bullet_motion_if: launch inputs, wall/hit flags and bullet state
// shared between the tank, the wall-collision stage and a bullet.
interface bullet_motion_if;
  logic       fire;
  logic [9:0] tankX;
  logic [9:0] tankY;
  logic [9:0] velX;
  logic [9:0] velY;
  logic       hit;
  logic       isWallBottom;
  logic       isWallTop;
  logic       isWallRight;
  logic       isWallLeft;
  logic [9:0] bulletX;
  logic [9:0] bulletY;
  logic [9:0] bulletS;
  logic       active;
  logic [2:0] bounces;

  modport master (
    output fire, tankX, tankY, velX, velY, hit,
    output isWallBottom, isWallTop, isWallRight, isWallLeft,
    input  bulletX, bulletY, bulletS, active, bounces
  );

  modport slave (
    input  fire, tankX, tankY, velX, velY, hit,
    input  isWallBottom, isWallTop, isWallRight, isWallLeft,
    output bulletX, bulletY, bulletS, active, bounces
  );
endinterface

// File: rtl/bullet_motion.sv
// bullet_motion: launches one bullet, moves it once per frame, reflects
// it off walls and retires it on lifetime, bounce limit or tank hit.
module bullet_motion #(
  parameter logic [9:0] BULLET_SIZE = 10'd4,
  parameter int         LIFETIME    = 600,
  parameter int         MAX_BOUNCE  = 5
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic           frame_clk,
  bullet_motion_if.slave bus
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] FLY  = 1'b1;

  localparam logic [9:0] LIFE = LIFETIME[9:0];
  localparam logic [2:0] MAXB = MAX_BOUNCE[2:0];

  logic [0:0] state;
  logic [2:0] fsync;
  logic       fire_d;
  logic       armed;
  logic [9:0] x;
  logic [9:0] y;
  logic [9:0] vx;
  logic [9:0] vy;
  logic [9:0] life;
  logic [2:0] bnc;

  logic       frame_tick;
  logic       fire_rise;
  logic       refl_x;
  logic       refl_y;
  logic       refl;
  logic [9:0] vx_n;
  logic [9:0] vy_n;

  assign frame_tick = fsync[1] & ~fsync[2];

  // armed blocks a launch from a fire level held across reset release
  assign fire_rise = bus.fire & ~fire_d & armed;

  assign refl_y = (bus.isWallBottom & ~vy[9] & (|vy))
                | (bus.isWallTop & vy[9]);
  assign refl_x = (bus.isWallRight & ~vx[9] & (|vx))
                | (bus.isWallLeft & vx[9]);
  assign refl   = refl_x | refl_y;

  assign vx_n = refl_x ? (10'd0 - vx) : vx;
  assign vy_n = refl_y ? (10'd0 - vy) : vy;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state  <= IDLE;
      fsync  <= 3'b000;
      fire_d <= 1'b0;
      armed  <= 1'b0;
      x      <= 10'd0;
      y      <= 10'd0;
      vx     <= 10'd0;
      vy     <= 10'd0;
      life   <= 10'd0;
      bnc    <= 3'd0;
    end else begin
      fsync  <= {fsync[1:0], frame_clk};
      fire_d <= bus.fire;
      armed  <= 1'b1;
      unique case (state)
        IDLE: begin
          if (fire_rise) begin
            x     <= bus.tankX;
            y     <= bus.tankY;
            vx    <= bus.velX;
            vy    <= bus.velY;
            life  <= LIFE;
            bnc   <= 3'd0;
            state <= FLY;
          end
        end
        FLY: begin
          if (bus.hit) begin
            state <= IDLE;
          end else if (frame_tick) begin
            if (refl && (bnc == MAXB)) begin
              state <= IDLE;
            end else begin
              vx   <= vx_n;
              vy   <= vy_n;
              x    <= x + vx_n;
              y    <= y + vy_n;
              life <= life - 10'd1;
              if (refl)
                bnc <= bnc + 3'd1;
              if (life == 10'd1)
                state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.bulletX = x;
  assign bus.bulletY = y;
  assign bus.bulletS = BULLET_SIZE;
  assign bus.active  = (state == FLY);
  assign bus.bounces = bnc;

endmodule
